rover_motion_arbiter: RTL and testbench

- Sits between the manual and automated rover controllers and the L298-style H-bridge pins.
- Each cycle it selects one command source and blocks forward motion while an obstacle is present.
- On any direction reversal or source change it inserts a dead-time interval with all motors off.
- Generates the ENA/ENB speed PWM, so the top level drives the motor pins from this block only.

---
 rtl/rover_motion_arbiter.sv | 170 +++++++++++++++++
 tb/tb_rover_motion_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rover_motion_arbiter.sv
// rover_motion_arbiter: picks the manual or automated drive command, suppresses
// forward motion while an obstacle is reported, inserts a motors-off dead time
// on direction reversals or source changes, and generates the ENA/ENB speed PWM.
// All motor pins are active-low and registered.
module rover_motion_arbiter #(
   parameter int unsigned DEAD_CYCLES = 50000,
   parameter int unsigned PWM_PERIOD  = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       auto_mode_switch,
   input  logic       object_detected,
   input  logic [2:0] man_dir,
   input  logic [1:0] man_speed,
   input  logic [2:0] auto_dir,
   input  logic [1:0] auto_speed,
   output logic       ENA,
   output logic       ENB,
   output logic       IN1,
   output logic       IN2,
   output logic       IN3,
   output logic       IN4,
   output logic       active_src,
   output logic       dead_active,
   output logic       fwd_blocked
);

   localparam int unsigned QUARTER = PWM_PERIOD / 4;
   localparam int unsigned CW      = $clog2(PWM_PERIOD + 1);
   localparam int unsigned DW      = $clog2(DEAD_CYCLES + 1);

   typedef enum logic [1:0] {ST_STOP, ST_DRIVE, ST_DEAD} state_t;
   typedef enum logic [2:0] {
      D_STOP  = 3'd0,
      D_FWD   = 3'd1,
      D_REV   = 3'd2,
      D_LEFT  = 3'd3,
      D_RIGHT = 3'd4
   } dir_t;

   // Active-low pin pattern {IN1, IN2, IN3, IN4} for each direction.
   function automatic logic [3:0] pin_map(input dir_t d);
      case (d)
         D_FWD:   pin_map = 4'b0101;
         D_REV:   pin_map = 4'b1010;
         D_LEFT:  pin_map = 4'b1001;
         D_RIGHT: pin_map = 4'b0110;
         default: pin_map = 4'b1111;
      endcase
   endfunction

   logic          mode_m, mode_s, obj_m, obj_s;
   state_t        state, state_n;
   dir_t          dir_q, dir_n;
   logic [1:0]    spd_q, spd_n;
   logic          src_q, src_n;
   logic [DW-1:0] dead_cnt, cnt_n;
   logic [CW-1:0] pwm_cnt, pwm_n, duty_n;

   logic [2:0]    sel_raw;
   logic [1:0]    sel_speed;
   dir_t          sel_dir, eff_dir;

   // Two-flop synchronisers for the asynchronous mode and obstacle levels.
   always_ff @(posedge clock) begin
      if (reset) begin
         mode_m <= 1'b0;
         mode_s <= 1'b0;
         obj_m  <= 1'b0;
         obj_s  <= 1'b0;
      end else begin
         mode_m <= auto_mode_switch;
         mode_s <= mode_m;
         obj_m  <= object_detected;
         obj_s  <= obj_m;
      end
   end

   // Source selection, illegal-code folding and obstacle masking of forward.
   always_comb begin
      sel_raw   = mode_s ? auto_dir : man_dir;
      sel_speed = mode_s ? auto_speed : man_speed;
      sel_dir   = (sel_raw > 3'd4) ? D_STOP : dir_t'(sel_raw);
      eff_dir   = (obj_s && (sel_dir == D_FWD)) ? D_STOP : sel_dir;
   end

   // Next-state logic for the STOP / DRIVE / DEAD controller and PWM counter.
   always_comb begin
      state_n = state;
      dir_n   = dir_q;
      spd_n   = spd_q;
      src_n   = src_q;
      cnt_n   = dead_cnt;
      case (state)
         ST_STOP: begin
            if (eff_dir != D_STOP) begin
               dir_n   = eff_dir;
               spd_n   = sel_speed;
               src_n   = mode_s;
               state_n = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (eff_dir == D_STOP) begin
               state_n = ST_STOP;
            end else if ((eff_dir != dir_q) || (mode_s != src_q)) begin
               cnt_n   = DW'(DEAD_CYCLES - 1);
               state_n = ST_DEAD;
            end else begin
               spd_n = sel_speed;
            end
         end
         ST_DEAD: begin
            if (eff_dir == D_STOP) begin
               state_n = ST_STOP;
            end else if (dead_cnt == '0) begin
               dir_n   = eff_dir;
               spd_n   = sel_speed;
               src_n   = mode_s;
               state_n = ST_DRIVE;
            end else begin
               cnt_n = dead_cnt - DW'(1);
            end
         end
         default: state_n = ST_STOP;
      endcase

      pwm_n  = (pwm_cnt == CW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt + CW'(1);
      duty_n = CW'((32'(spd_n) + 32'd1) * QUARTER);
   end

   // State registers and pins; pins are decoded from next-state values so
   // they reflect the registered state without a combinational output path.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_STOP;
         dir_q       <= D_STOP;
         spd_q       <= '0;
         src_q       <= 1'b0;
         dead_cnt    <= '0;
         pwm_cnt     <= '0;
         {IN1, IN2, IN3, IN4} <= '1;
         ENA         <= 1'b1;
         ENB         <= 1'b1;
         active_src  <= 1'b0;
         dead_active <= 1'b0;
         fwd_blocked <= 1'b0;
      end else begin
         state    <= state_n;
         dir_q    <= dir_n;
         spd_q    <= spd_n;
         src_q    <= src_n;
         dead_cnt <= cnt_n;
         pwm_cnt  <= pwm_n;
         if (state_n == ST_DRIVE) begin
            {IN1, IN2, IN3, IN4} <= pin_map(dir_n);
            ENA        <= !(pwm_n < duty_n);
            ENB        <= !(pwm_n < duty_n);
            active_src <= src_n;
         end else begin
            {IN1, IN2, IN3, IN4} <= '1;
            ENA <= 1'b1;
            ENB <= 1'b1;
         end
         dead_active <= (state_n == ST_DEAD);
         fwd_blocked <= obj_s && (sel_dir == D_FWD);
      end
   end

endmodule

// File: tb/tb_rover_motion_arbiter.sv
// Directed bench for rover_motion_arbiter with DEAD_CYCLES=4, PWM_PERIOD=8.
module tb_rover_motion_arbiter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       auto_mode_switch = 1'b0;
   logic       object_detected = 1'b0;
   logic [2:0] man_dir = '0;
   logic [1:0] man_speed = '0;
   logic [2:0] auto_dir = '0;
   logic [1:0] auto_speed = '0;
   logic       ENA, ENB, IN1, IN2, IN3, IN4;
   logic       active_src, dead_active, fwd_blocked;

   int checks = 0;
   int errors = 0;

   rover_motion_arbiter #(
      .DEAD_CYCLES(4),
      .PWM_PERIOD (8)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .auto_mode_switch(auto_mode_switch),
      .object_detected (object_detected),
      .man_dir         (man_dir),
      .man_speed       (man_speed),
      .auto_dir        (auto_dir),
      .auto_speed      (auto_speed),
      .ENA             (ENA),
      .ENB             (ENB),
      .IN1             (IN1),
      .IN2             (IN2),
      .IN3             (IN3),
      .IN4             (IN4),
      .active_src      (active_src),
      .dead_active     (dead_active),
      .fwd_blocked     (fwd_blocked)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic [2:0] mdir;
      logic [1:0] mspd;
      logic [3:0] pins;
      logic       dead;
      logic       en_care;
      logic       en;
   } vec_t;

   vec_t vecs[17];

   function automatic logic [3:0] pins();
      return {IN1, IN2, IN3, IN4};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      auto_mode_switch = 1'b0;
      object_detected = 1'b0;
      man_dir = 3'd0;
      man_speed = 2'd0;
      auto_dir = 3'd0;
      auto_speed = 2'd0;
      step();
      step();
      reset = 1'b0;
   endtask

   // Counts DEAD cycles starting from one already observed; bounded wait.
   task automatic measure_dead(input string name);
      int n = 1;
      for (int k = 0; k < 20 && dead_active; k++) begin
         step();
         if (dead_active) n++;
      end
      check({name, "_len"}, n, 4);
      check({name, "_ended"}, dead_active, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      // rst, man_dir, man_speed, pins {IN1..IN4}, dead, en_care, en
      vecs[0]  = '{1'b1, 3'd0, 2'd0, 4'b1111, 1'b0, 1'b1, 1'b1};
      vecs[1]  = '{1'b1, 3'd0, 2'd0, 4'b1111, 1'b0, 1'b1, 1'b1};
      vecs[2]  = '{1'b0, 3'd1, 2'd1, 4'b0101, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 3'd1, 2'd1, 4'b0101, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 3'd3, 2'd1, 4'b1111, 1'b1, 1'b1, 1'b1};
      vecs[5]  = '{1'b0, 3'd3, 2'd1, 4'b1111, 1'b1, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 3'd3, 2'd1, 4'b1111, 1'b1, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 3'd3, 2'd1, 4'b1111, 1'b1, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 3'd3, 2'd1, 4'b1001, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 3'd7, 2'd1, 4'b1111, 1'b0, 1'b1, 1'b1};
      vecs[10] = '{1'b0, 3'd4, 2'd1, 4'b0110, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 3'd5, 2'd1, 4'b1111, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 3'd2, 2'd3, 4'b1010, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 3'd0, 2'd3, 4'b1111, 1'b0, 1'b1, 1'b1};
      vecs[14] = '{1'b0, 3'd2, 2'd3, 4'b1010, 1'b0, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 3'd4, 2'd3, 4'b1111, 1'b1, 1'b1, 1'b1};
      vecs[16] = '{1'b0, 3'd0, 2'd3, 4'b1111, 1'b0, 1'b1, 1'b1};

      #1;
      for (int i = 0; i < 17; i++) begin
         reset = vecs[i].rst;
         man_dir = vecs[i].mdir;
         man_speed = vecs[i].mspd;
         step();
         check($sformatf("vec%0d_pins", i), pins(), vecs[i].pins);
         check($sformatf("vec%0d_dead", i), dead_active, vecs[i].dead);
         check($sformatf("vec%0d_src", i), active_src, 1'b0);
         check($sformatf("vec%0d_fwdblk", i), fwd_blocked, 1'b0);
         check($sformatf("vec%0d_en_pair", i), ENA, ENB);
         if (vecs[i].en_care) check($sformatf("vec%0d_ena", i), ENA, vecs[i].en);
      end

      // PWM duty at speeds 1, 3 and 0
      do_reset();
      man_dir = 3'd1;
      man_speed = 2'd1;
      step();
      check("pwm_fwd_pins", pins(), 4'b0101);
      lows = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (!ENA) lows++;
         check("pwm_en_pair", ENA, ENB);
      end
      check("pwm_spd1_lows", lows, 4);
      man_speed = 2'd3;
      for (int k = 0; k < 8; k++) begin
         step();
         check("pwm_spd3_ena", ENA, 1'b0);
         check("pwm_spd3_nodead", dead_active, 1'b0);
      end
      man_speed = 2'd0;
      lows = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (!ENA) lows++;
      end
      check("pwm_spd0_lows", lows, 2);

      // Obstacle while driving forward, then reverse and re-request forward
      man_speed = 2'd1;
      object_detected = 1'b1;
      step();
      step();
      check("obs_latency_pins", pins(), 4'b0101);
      step();
      check("obs_stop_pins", pins(), 4'b1111);
      check("obs_fwdblk", fwd_blocked, 1'b1);
      check("obs_nodead", dead_active, 1'b0);
      check("obs_ena", ENA, 1'b1);
      man_dir = 3'd2;
      step();
      check("obs_rev_pins", pins(), 4'b1010);
      check("obs_rev_nodead", dead_active, 1'b0);
      check("obs_rev_fwdblk", fwd_blocked, 1'b0);
      man_dir = 3'd1;
      step();
      check("obs_refwd_pins", pins(), 4'b1111);
      check("obs_refwd_fwdblk", fwd_blocked, 1'b1);
      step();
      step();
      check("obs_hold_pins", pins(), 4'b1111);
      check("obs_hold_nodead", dead_active, 1'b0);

      // Source change manual -> auto
      do_reset();
      man_dir = 3'd1;
      man_speed = 2'd1;
      auto_dir = 3'd1;
      auto_speed = 2'd3;
      step();
      step();
      check("mode_man_pins", pins(), 4'b0101);
      auto_mode_switch = 1'b1;
      step();
      step();
      check("mode_sync_nodead", dead_active, 1'b0);
      check("mode_sync_pins", pins(), 4'b0101);
      step();
      check("mode_dead_start", dead_active, 1'b1);
      check("mode_dead_pins", pins(), 4'b1111);
      check("mode_dead_src_hold", active_src, 1'b0);
      measure_dead("mode_dead");
      check("mode_auto_pins", pins(), 4'b0101);
      check("mode_auto_src", active_src, 1'b1);
      check("mode_auto_ena", ENA, 1'b0);

      // Source change and direction change together: one DEAD interval
      auto_mode_switch = 1'b0;
      man_dir = 3'd2;
      step();
      step();
      check("both_sync_nodead", dead_active, 1'b0);
      step();
      check("both_dead_start", dead_active, 1'b1);
      measure_dead("both_dead");
      check("both_rev_pins", pins(), 4'b1010);
      check("both_rev_src", active_src, 1'b0);
      step();
      check("both_single_dead", dead_active, 1'b0);

      // Reset during the second DEAD cycle
      do_reset();
      man_dir = 3'd1;
      man_speed = 2'd1;
      step();
      check("rst_fwd_pins", pins(), 4'b0101);
      man_dir = 3'd2;
      step();
      check("rst_dead1", dead_active, 1'b1);
      step();
      check("rst_dead2", dead_active, 1'b1);
      reset = 1'b1;
      man_dir = 3'd1;
      step();
      check("rst_pins", pins(), 4'b1111);
      check("rst_ena", ENA, 1'b1);
      check("rst_enb", ENB, 1'b1);
      check("rst_dead", dead_active, 1'b0);
      check("rst_src", active_src, 1'b0);
      check("rst_fwdblk", fwd_blocked, 1'b0);
      reset = 1'b0;
      step();
      check("rst_resume_pins", pins(), 4'b0101);
      check("rst_resume_nodead", dead_active, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
